// File: rtl/game_state_ctrl.sv
// Frame-rate game flow controller: START / PLAY / PAUSE / OVER sequencing,
// lives and win tracking, edge-detected key presses and a free-running frame counter.
module game_state_ctrl #(
  parameter logic [7:0] START_KEY   = 8'h28,
  parameter logic [7:0] PAUSE_KEY   = 8'h13,
  parameter int         LIVES_INIT  = 3,
  parameter int         OVER_FRAMES = 128
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       playerDead,
  input  logic       bossDead,
  output logic [5:0] FrameCount,
  output logic [1:0] gameState,
  output logic [1:0] lives,
  output logic       win,
  output logic       gameReset,
  output logic       respawn
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [7:0] EARLY_MIN  = 8'd32;
  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

  state_t     state_q;
  logic [7:0] prev_key_q;
  logic [7:0] over_timer_q;
  logic       start_press;
  logic       pause_press;
  logic       start_game;

  // A press is the first frame a key is seen; holding it yields nothing more.
  assign start_press = (keycode == START_KEY) && (prev_key_q != START_KEY);
  assign pause_press = (keycode == PAUSE_KEY) && (prev_key_q != PAUSE_KEY);

  // Early restart out of OVER is only honoured once the lockout window has passed.
  assign start_game  = start_press &&
                       ((state_q == ST_START) ||
                        ((state_q == ST_OVER) && (over_timer_q >= EARLY_MIN)));

  assign gameState = state_q;

  always_ff @(posedge frame_Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_START;
      prev_key_q   <= 8'h00;
      over_timer_q <= 8'h00;
      FrameCount   <= 6'd0;
      lives        <= 2'd0;
      win          <= 1'b0;
      gameReset    <= 1'b0;
      respawn      <= 1'b0;
    end else begin
      FrameCount <= FrameCount + 6'd1;
      prev_key_q <= keycode;
      gameReset  <= 1'b0;
      respawn    <= 1'b0;

      if (start_game) begin
        state_q   <= ST_PLAY;
        lives     <= LIVES_LOAD;
        win       <= 1'b0;
        gameReset <= 1'b1;
      end else begin
        case (state_q)
          ST_START: ;
          ST_PLAY: begin
            // Boss defeat outranks a simultaneous death or pause request.
            if (bossDead) begin
              state_q      <= ST_OVER;
              win          <= 1'b1;
              over_timer_q <= 8'h00;
            end else if (playerDead) begin
              if (lives > 2'd1) begin
                lives   <= lives - 2'd1;
                respawn <= 1'b1;
              end else begin
                lives        <= 2'd0;
                win          <= 1'b0;
                state_q      <= ST_OVER;
                over_timer_q <= 8'h00;
              end
            end else if (pause_press) begin
              state_q <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (pause_press) state_q <= ST_PLAY;
          end
          ST_OVER: begin
            over_timer_q <= over_timer_q + 8'd1;
            if (over_timer_q == OVER_LAST) state_q <= ST_START;
          end
          default: state_q <= ST_START;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed vector table, hand-written corner sequences
// and random frames, all checked against a frame-level reference model.
module tb_game_state_ctrl;

  localparam logic [7:0] K_START = 8'h28;
  localparam logic [7:0] K_PAUSE = 8'h13;
  localparam int M_START = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3;

  logic       frame_Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       playerDead = 1'b0;
  logic       bossDead = 1'b0;
  logic [5:0] FrameCount;
  logic [1:0] gameState;
  logic [1:0] lives;
  logic       win;
  logic       gameReset;
  logic       respawn;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state (plain integers, one update per frame)
  int m_mode, m_lives, m_win, m_fc, m_t, m_prev, m_gr, m_rsp;

  game_state_ctrl dut (
    .frame_Clk (frame_Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .playerDead(playerDead),
    .bossDead  (bossDead),
    .FrameCount(FrameCount),
    .gameState (gameState),
    .lives     (lives),
    .win       (win),
    .gameReset (gameReset),
    .respawn   (respawn)
  );

  always #5 frame_Clk = ~frame_Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_START; m_lives = 0; m_win = 0; m_fc = 0;
    m_t = 0; m_prev = 0; m_gr = 0; m_rsp = 0;
  endtask

  task automatic model_step(input int k, input bit pd, input bit bd);
    bit start_p, pause_p, can_start;
    start_p   = (k == int'(K_START)) && (m_prev != int'(K_START));
    pause_p   = (k == int'(K_PAUSE)) && (m_prev != int'(K_PAUSE));
    can_start = (m_mode == M_START) || (m_mode == M_OVER && m_t >= 32);
    m_gr = 0; m_rsp = 0;
    m_fc = (m_fc + 1) % 64;
    m_prev = k;
    if (start_p && can_start) begin
      m_mode = M_PLAY; m_lives = 3; m_win = 0; m_gr = 1;
    end else if (m_mode == M_PLAY) begin
      if (bd) begin
        m_mode = M_OVER; m_win = 1; m_t = 0;
      end else if (pd && m_lives > 1) begin
        m_lives = m_lives - 1; m_rsp = 1;
      end else if (pd) begin
        m_lives = 0; m_win = 0; m_mode = M_OVER; m_t = 0;
      end else if (pause_p) begin
        m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE) begin
      if (pause_p) m_mode = M_PLAY;
    end else if (m_mode == M_OVER) begin
      if (m_t == 127) m_mode = M_START;
      m_t = m_t + 1;
    end
  endtask

  task automatic check_model();
    chk("frame_count", FrameCount, m_fc);
    chk("game_state",  gameState,  m_mode);
    chk("lives",       lives,      m_lives);
    chk("win",         win,        m_win);
    chk("game_reset",  gameReset,  m_gr);
    chk("respawn",     respawn,    m_rsp);
  endtask

  task automatic tick(input logic [7:0] k, input logic pd, input logic bd);
    keycode = k; playerDead = pd; bossDead = bd;
    @(posedge frame_Clk);
    model_step(int'(k), pd, bd);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, gameState, 0);
    chk({tag, "_fc"},    FrameCount, 0);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_win"},   win, 0);
    chk({tag, "_gr"},    gameReset, 0);
    chk({tag, "_rsp"},   respawn, 0);
  endtask

  typedef struct {
    logic [7:0] key;
    logic       pd;
    logic       bd;
    logic [1:0] st;
    logic [1:0] lv;
    logic       w;
    logic       gr;
    logic       rsp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    bit done;
    logic [7:0] k;
    logic [7:0] last_k;

    // start from START with all inputs idle: held key, three deaths
    vecs[0]  = '{K_START, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{K_START, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{K_START, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{K_START, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{K_START, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00,   1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h00,   1'b0, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h00,   1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'h00,   1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h00,   1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h00,   1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0};

    model_reset();
    repeat (3) @(posedge frame_Clk);
    #1;
    check_reset_values("por");
    @(negedge frame_Clk);
    Reset = 1'b1;

    // idle frames: counter 1..63, 0..6 after each edge, state stays START
    for (int i = 1; i <= 70; i++) begin
      tick(8'h00, 1'b0, 1'b0);
      chk("fc_seq", FrameCount, i % 64);
      chk("idle_state", gameState, 0);
    end

    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].key, vecs[i].pd, vecs[i].bd);
      chk($sformatf("vec%0d_state", i), gameState, vecs[i].st);
      chk($sformatf("vec%0d_lives", i), lives, vecs[i].lv);
      chk($sformatf("vec%0d_win", i),   win, vecs[i].w);
      chk($sformatf("vec%0d_gr", i),    gameReset, vecs[i].gr);
      chk($sformatf("vec%0d_rsp", i),   respawn, vecs[i].rsp);
    end

    // leave OVER early once the lockout has passed
    n = 0;
    while (m_t < 40 && n < 300) begin tick(8'h00, 1'b0, 1'b0); n++; end
    tick(K_START, 1'b0, 1'b0);
    chk("restart_state", gameState, 1);
    chk("restart_gr", gameReset, 1);
    chk("restart_lives", lives, 3);

    // boss, death and pause in the same frame: boss wins, lives untouched
    tick(8'h00, 1'b0, 1'b0);
    tick(K_PAUSE, 1'b1, 1'b1);
    chk("boss_prio_state", gameState, 3);
    chk("boss_prio_win", win, 1);
    chk("boss_prio_lives", lives, 3);

    // early press at timer 10 is dropped; OVER lasts 128 frames
    done = 1'b0;
    for (n = 0; n < 300 && !done; n++) begin
      tick((n == 10) ? K_START : 8'h00, 1'b0, 1'b0);
      if (n == 10) chk("early_press_ignored", gameState, 3);
      if (gameState == 2'd0) done = 1'b1;
    end
    chk("over_timeout_done", int'(done), 1);
    chk("over_frames", n, 128);

    // again, with a press at timer 40
    tick(K_START, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b1);
    chk("over2_state", gameState, 3);
    n = 0;
    while (m_t < 40 && n < 300) begin tick(8'h00, 1'b0, 1'b0); n++; end
    chk("timer40_reached", m_t, 40);
    tick(K_START, 1'b0, 1'b0);
    chk("press40_state", gameState, 1);
    chk("press40_gr", gameReset, 1);
    tick(K_START, 1'b0, 1'b0);
    chk("press40_gr_once", gameReset, 0);

    // PAUSE ignores deaths and the start key
    tick(8'h00, 1'b0, 1'b0);
    tick(K_PAUSE, 1'b0, 1'b0);
    chk("pause_enter", gameState, 2);
    tick(K_START, 1'b1, 1'b1);
    chk("pause_hold_state", gameState, 2);
    chk("pause_hold_lives", lives, 3);
    chk("pause_hold_gr", gameReset, 0);
    tick(8'h00, 1'b1, 1'b0);
    tick(K_PAUSE, 1'b0, 1'b0);
    chk("pause_exit_state", gameState, 1);
    chk("pause_exit_lives", lives, 3);
    tick(8'h00, 1'b0, 1'b0);

    // asynchronous reset mid-PLAY, start key held through release
    #3;
    Reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    keycode = K_START;
    @(posedge frame_Clk);
    #1;
    check_reset_values("rst_held");
    @(negedge frame_Clk);
    Reset = 1'b1;
    tick(K_START, 1'b0, 1'b0);
    chk("held_key_start", gameState, 1);
    chk("held_key_gr", gameReset, 1);
    chk("held_key_lives", lives, 3);

    // random frames against the model
    last_k = K_START;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    k = 8'h00;
        2:       k = K_START;
        3:       k = K_PAUSE;
        4:       k = last_k;
        default: k = 8'($urandom_range(0, 255));
      endcase
      last_k = k;
      tick(k, ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter START_KEY, default 8'h28, keyboard code that starts or restarts a game.
REQ-002 Parameter PAUSE_KEY, default 8'h13, keyboard code that toggles pause.
REQ-003 Parameter LIVES_INIT, default 3, lives loaded at game start; legal range 1..3.
REQ-004 Parameter OVER_FRAMES, default 128, frames spent in OVER before auto-return to START; legal range 33..255.
REQ-005 frame_Clk  in  1  the only clock; one rising edge per video frame.
REQ-006 Reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
REQ-007 keycode  in  8  current keyboard code; 8'h00 means no key held.
REQ-008 playerDead  in  1  player death event, sampled once per frame.
REQ-009 bossDead  in  1  boss defeated event, sampled once per frame.
REQ-010 FrameCount  out  6  free-running frame counter, consumed by the screen muxes.
REQ-011 gameState  out  2  00 START, 01 PLAY, 10 PAUSE, 11 OVER.
REQ-012 lives  out  2  remaining lives.
REQ-013 win  out  1  high in OVER when the game ended by boss defeat.
REQ-014 gameReset  out  1  one-frame pulse that reinitialises game objects and scroll.
REQ-015 respawn  out  1  one-frame pulse on a non-final death.

Function
REQ-016 FrameCount SHALL increment by 1 every frame in all states, wrapping 63 -> 0.
REQ-017 A key press SHALL register only on the frame when keycode equals the key and the previous frame's keycode differed; a held key SHALL produce one press.
REQ-018 The previous-keycode register SHALL update every frame.
REQ-019 START -> PLAY on a START_KEY press; on that edge lives <= LIVES_INIT, win <= 0, and gameReset is high for that one frame.
REQ-020 PLAY -> PAUSE on a PAUSE_KEY press when playerDead and bossDead are both low.
REQ-021 PAUSE -> PLAY on a PAUSE_KEY press.
REQ-022 PAUSE SHALL ignore playerDead, bossDead and START_KEY.
REQ-023 In PLAY, bossDead SHALL cause -> OVER with win <= 1; it takes priority over playerDead and PAUSE_KEY in the same frame.
REQ-024 In PLAY, playerDead with lives > 1 SHALL set lives <= lives-1, stay in PLAY, and pulse respawn for one frame.
REQ-025 In PLAY, playerDead with lives == 1 SHALL set lives <= 0, go -> OVER with win <= 0, and not pulse respawn.
REQ-026 playerDead and bossDead SHALL be ignored in START and OVER.
REQ-027 overTimer (8-bit) SHALL load 0 on entry to OVER and increment once per frame in OVER.
REQ-028 OVER -> START when overTimer == OVER_FRAMES-1.
REQ-029 OVER -> PLAY early on a START_KEY press with overTimer >= 32; this behaves as REQ-019, including gameReset.
REQ-030 START_KEY presses in OVER with overTimer < 32 SHALL be discarded, not queued.
REQ-031 lives and win SHALL hold in START and OVER until the next game start.
REQ-032 All outputs SHALL be registered; state changes appear one frame_Clk edge after the qualifying input.

Reset
REQ-033 While Reset is low: gameState = START, FrameCount = 0, lives = 0, win = 0, gameReset = 0, respawn = 0, overTimer = 0, previous keycode = 8'h00.
REQ-034 Reset asserted mid-game SHALL abort to START immediately with no gameReset pulse; a key held through reset release SHALL count as a press on the first frame after release.

Verification
REQ-035 After reset, apply 70 frames with no input -> FrameCount goes 0..63, 0..5; gameState stays 00.
REQ-036 In START, hold keycode 8'h28 for 5 frames -> one transition to 01, lives = 3, gameReset high for exactly 1 frame; no further action.
REQ-037 In PLAY with lives = 3, give playerDead pulses on 3 separate frames -> lives 2, 1 with a respawn pulse each; the third gives lives = 0, gameState 11, win = 0, no respawn.
REQ-038 In PLAY, drive bossDead, playerDead and a PAUSE_KEY press in the same frame -> gameState 11, win = 1, lives unchanged.
REQ-039 In OVER, press START_KEY at overTimer 10 -> ignored; with no further input, -> 00 after 128 frames in OVER. Repeat with a press at overTimer 40 -> 01 plus a gameReset pulse.
REQ-040 In PAUSE, assert playerDead and press 8'h28 -> no change; press 8'h13 -> 01 with lives unchanged. Pull Reset low mid-PLAY -> all REQ-033 values hold on the same cycle.
